// File: rtl/apb_arb_pkg.sv
// apb_arb_pkg: shared FSM encoding, response codes and watchdog default for apb_cmd_arbiter
package apb_arb_pkg;
   typedef enum logic [1:0] {IDLE = 2'd0, ISSUE = 2'd1, WAIT = 2'd2, RESP = 2'd3} state_t;
   localparam logic [1:0] RESP_OKAY = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;
   localparam int WDOG_CYCLES_DEF = 256;
endpackage

// File: rtl/rr_pick.sv
// rr_pick: combinational round-robin selector, first set request at or above ptr modulo NUM_REQ
module rr_pick #(
   parameter int NUM_REQ = 2,
   parameter int IDXW = 1
) (
   input  logic [NUM_REQ-1:0] req,
   input  logic [IDXW-1:0]    ptr,
   output logic [NUM_REQ-1:0] gnt,
   output logic [IDXW-1:0]    idx
);
   function automatic logic [IDXW-1:0] wrap(input int v);
      return IDXW'(v % NUM_REQ);
   endfunction
   // descending scan so the candidate closest to ptr is the last one written
   always_comb begin
      idx = '0;
      for (int k = NUM_REQ - 1; k >= 0; k--)
         if (req[wrap(int'(ptr) + k)]) idx = wrap(int'(ptr) + k);
      gnt = (|req) ? NUM_REQ'(1) << idx : '0;
   end
endmodule

// File: rtl/apb_cmd_arbiter.sv
// apb_cmd_arbiter: round-robin sharing of one bridge start/done port; ARB_WATCHDOG_EN adds a WAIT timeout
module apb_cmd_arbiter
   import apb_arb_pkg::*;
#(
   parameter int NUM_REQ = 2,
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
`ifdef ARB_WATCHDOG_EN
   ,
   parameter int WDOG_CYCLES = WDOG_CYCLES_DEF
`endif
) (
   input  logic                        ACLK,
   input  logic                        ARESETn,
   input  logic [NUM_REQ-1:0]          req_valid,
   input  logic [NUM_REQ-1:0]          req_write,
   input  logic [NUM_REQ*ADDR_W-1:0]   req_addr,
   input  logic [NUM_REQ*DATA_W-1:0]   req_wdata,
   input  logic [NUM_REQ*DATA_W/8-1:0] req_wstrb,
   output logic [NUM_REQ-1:0]          req_ready,
   output logic [NUM_REQ-1:0]          rsp_valid,
   output logic [DATA_W-1:0]           rsp_rdata,
   output logic [1:0]                  rsp_resp,
   output logic                        start,
   output logic                        write,
   output logic [ADDR_W-1:0]           addr,
   output logic [DATA_W-1:0]           wdata,
   output logic [DATA_W/8-1:0]         wstrb,
   input  logic                        busy,
   input  logic                        done,
   input  logic [DATA_W-1:0]           rdata,
   input  logic [1:0]                  resp
);
   localparam int IDXW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
   localparam int SW = DATA_W / 8;
   state_t state, nxt;
   logic [IDXW-1:0] g, rr_ptr, pick_idx;
   logic [NUM_REQ-1:0] pick_gnt;
   logic take, cap, wdog_hit;
   rr_pick #(.NUM_REQ(NUM_REQ), .IDXW(IDXW)) u_pick (
      .req(req_valid),
      .ptr(rr_ptr),
      .gnt(pick_gnt),
      .idx(pick_idx)
   );
`ifdef ARB_WATCHDOG_EN
   localparam int WCW = (WDOG_CYCLES > 2) ? $clog2(WDOG_CYCLES) : 1;
   logic [WCW-1:0] wcnt;
   always_ff @(posedge ACLK or negedge ARESETn)
      if (!ARESETn) wcnt <= '0;
      else wcnt <= (state == WAIT) ? wcnt + 1'b1 : '0;
   // a real done in the timeout cycle wins over the synthetic error
   assign wdog_hit = (state == WAIT) && !done && (wcnt == WCW'(WDOG_CYCLES - 1));
`else
   assign wdog_hit = 1'b0;
`endif
   always_ff @(posedge ACLK or negedge ARESETn)
      if (!ARESETn) state <= IDLE;
      else state <= nxt;
   always_comb begin
      nxt = state;
      take = 1'b0;
      cap = 1'b0;
      case (state)
         IDLE: begin
            take = |req_valid && !busy;
            nxt = take ? ISSUE : IDLE;
         end
         ISSUE: begin
            cap = done;
            nxt = done ? RESP : WAIT;
         end
         WAIT: begin
            cap = done || wdog_hit;
            nxt = cap ? RESP : WAIT;
         end
         RESP: nxt = IDLE;
      endcase
   end
   always_ff @(posedge ACLK or negedge ARESETn)
      if (!ARESETn) begin
         g <= '0;
         rr_ptr <= '0;
         start <= 1'b0;
         req_ready <= '0;
         rsp_valid <= '0;
         write <= 1'b0;
         addr <= '0;
         wdata <= '0;
         wstrb <= '0;
         rsp_rdata <= '0;
         rsp_resp <= RESP_OKAY;
      end else begin
         start <= take;
         req_ready <= take ? pick_gnt : '0;
         rsp_valid <= cap ? NUM_REQ'(1) << g : '0;
         if (take) begin
            g <= pick_idx;
            write <= req_write[pick_idx];
            addr <= req_addr[pick_idx*ADDR_W +: ADDR_W];
            wdata <= req_wdata[pick_idx*DATA_W +: DATA_W];
            wstrb <= req_wstrb[pick_idx*SW +: SW];
         end
         if (cap) begin
            rsp_rdata <= wdog_hit ? '0 : rdata;
            rsp_resp <= wdog_hit ? RESP_SLVERR : resp;
         end
         if (state == RESP) rr_ptr <= (g == IDXW'(NUM_REQ - 1)) ? '0 : g + 1'b1;
      end
endmodule
